// File: rtl/selective_blink_ctrl_pkg.sv
// Shared constants for the selective blink controller: FSM state codes, LED count,
// select width and the press priority helper.
package selective_blink_ctrl_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_BLINK = 1'b1;

    localparam int NUM_LEDS = 4;
    localparam int SEL_W    = 2;

    // Lowest set index wins when several switches rise in the same cycle.
    function automatic logic [SEL_W-1:0] lowest_index(input logic [NUM_LEDS-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = NUM_LEDS - 1; i >= 0; i--) begin
            if (v[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/selective_blink_ctrl_switch_edge_detect.sv
// Rising-edge detector for one debounced switch: registers the level and flags
// a press when the switch is high and the previous level was low.
module selective_blink_ctrl_switch_edge_detect (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Rise
);

    logic r_prev;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) r_prev <= 1'b0;
        else       r_prev <= i_Switch;
    end

    assign o_Rise = i_Switch & ~r_prev;

endmodule

// File: rtl/selective_blink_ctrl.sv
// Selective blink controller: a switch press picks one of four LEDs, which toggles on
// every blink-rate tick. Optional auto-stop after N toggles via SELECTIVE_BLINK_TIMEOUT_EN.
module selective_blink_ctrl
    import selective_blink_ctrl_pkg::*;
#(
    parameter int TIMEOUT_TOGGLES = 20,
    parameter bit LED_ACTIVE_HIGH = 1'b1
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Enable,
    input  logic             i_Switch_1,
    input  logic             i_Switch_2,
    input  logic             i_Switch_3,
    input  logic             i_Switch_4,
    output logic             o_LED_1,
    output logic             o_LED_2,
    output logic             o_LED_3,
    output logic             o_LED_4,
    output logic             o_Busy,
    output logic [SEL_W-1:0] o_Sel,
    output logic             o_Timeout
);

    // Count must hold 255 (saturating mode) and 2*TIMEOUT_TOGGLES-2 (auto-stop mode).
    localparam int CNT_W = ($clog2(2 * TIMEOUT_TOGGLES) > 8) ? $clog2(2 * TIMEOUT_TOGGLES) : 8;

    logic [NUM_LEDS-1:0] w_switch;
    logic [NUM_LEDS-1:0] w_press;
    logic                w_any_press;
    logic [SEL_W-1:0]    w_press_idx;

    logic                r_state, w_state_nxt;
    logic [SEL_W-1:0]    r_sel, w_sel_nxt;
    logic                r_phase, w_phase_nxt;
    logic [CNT_W-1:0]    r_count, w_count_nxt;
    logic [NUM_LEDS-1:0] w_led;

    assign w_switch = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_edge
        selective_blink_ctrl_switch_edge_detect u_edge (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Switch (w_switch[g]),
            .o_Rise   (w_press[g])
        );
    end

    assign w_any_press = |w_press;
    assign w_press_idx = lowest_index(w_press);

`ifdef SELECTIVE_BLINK_TIMEOUT_EN
    logic r_timeout, w_timeout_nxt;
`endif

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_phase <= 1'b0;
            r_count <= '0;
`ifdef SELECTIVE_BLINK_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_phase <= w_phase_nxt;
            r_count <= w_count_nxt;
`ifdef SELECTIVE_BLINK_TIMEOUT_EN
            r_timeout <= w_timeout_nxt;
`endif
        end
    end

    // A press always outranks a tick (and the timeout) in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_phase_nxt = r_phase;
        w_count_nxt = r_count;
`ifdef SELECTIVE_BLINK_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any_press) begin
                    w_state_nxt = ST_BLINK;
                    w_sel_nxt   = w_press_idx;
                    w_phase_nxt = 1'b1;
                    w_count_nxt = '0;
                end
            end
            ST_BLINK: begin
                if (w_any_press) begin
                    if (w_press_idx == r_sel) begin
                        w_state_nxt = ST_IDLE;
                        w_sel_nxt   = '0;
                        w_phase_nxt = 1'b0;
                    end else begin
                        w_sel_nxt   = w_press_idx;
                        w_phase_nxt = 1'b1;
                    end
                    w_count_nxt = '0;
                end else if (i_Enable) begin
`ifdef SELECTIVE_BLINK_TIMEOUT_EN
                    if (r_count == CNT_W'(2 * TIMEOUT_TOGGLES - 2)) begin
                        w_state_nxt   = ST_IDLE;
                        w_sel_nxt     = '0;
                        w_phase_nxt   = 1'b0;
                        w_count_nxt   = '0;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = ~r_phase;
                        w_count_nxt = r_count + CNT_W'(1);
                    end
`else
                    w_phase_nxt = ~r_phase;
                    if (r_count != CNT_W'(255)) w_count_nxt = r_count + CNT_W'(1);
`endif
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = '0;
                w_phase_nxt = 1'b0;
                w_count_nxt = '0;
            end
        endcase
    end

    // Only LED[sel] can ever be lit; decode depends on registers only.
    always_comb begin
        w_led = '0;
        if (r_state == ST_BLINK && r_phase) w_led[r_sel] = 1'b1;
    end

    assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = LED_ACTIVE_HIGH ? w_led : ~w_led;
    assign o_Busy = (r_state == ST_BLINK);
    assign o_Sel  = r_sel;
`ifdef SELECTIVE_BLINK_TIMEOUT_EN
    assign o_Timeout = r_timeout;
`else
    assign o_Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_selective_blink_ctrl.sv
// Bench for selective_blink_ctrl: an active-high and an active-low instance share stimulus;
// a behavioural model pushes expected outputs that are popped after each clock edge.
module tb_selective_blink_ctrl;

`ifdef SELECTIVE_BLINK_TIMEOUT_EN
    localparam int TB_TIMEOUT = 2;
`else
    localparam int TB_TIMEOUT = 20;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] sw;

    logic       a_led1, a_led2, a_led3, a_led4, a_busy, a_to;
    logic [1:0] a_sel;
    logic       b_led1, b_led2, b_led3, b_led4, b_busy, b_to;
    logic [1:0] b_sel;

    always #5 clk = ~clk;

    selective_blink_ctrl #(.TIMEOUT_TOGGLES(TB_TIMEOUT), .LED_ACTIVE_HIGH(1'b1)) dut_a (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
        .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
        .o_LED_1(a_led1), .o_LED_2(a_led2), .o_LED_3(a_led3), .o_LED_4(a_led4),
        .o_Busy(a_busy), .o_Sel(a_sel), .o_Timeout(a_to)
    );

    selective_blink_ctrl #(.TIMEOUT_TOGGLES(TB_TIMEOUT), .LED_ACTIVE_HIGH(1'b0)) dut_b (
        .i_Clk(clk), .i_Rst(rst), .i_Enable(en),
        .i_Switch_1(sw[0]), .i_Switch_2(sw[1]), .i_Switch_3(sw[2]), .i_Switch_4(sw[3]),
        .o_LED_1(b_led1), .o_LED_2(b_led2), .o_LED_3(b_led3), .o_LED_4(b_led4),
        .o_Busy(b_busy), .o_Sel(b_sel), .o_Timeout(b_to)
    );

    // Scoreboard: {led4..led1, busy, sel[1:0], timeout} for the active-high view
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_state;
    logic [1:0] m_sel;
    logic       m_phase;
    int         m_count;
    logic [3:0] m_prev;
    logic       m_timeout;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b (led4..1,busy,sel,timeout) at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_out();
        logic [3:0] led;
        led = (m_state && m_phase) ? (4'b0001 << m_sel) : 4'b0000;
        return {led, m_state, m_sel, m_timeout};
    endfunction

    task automatic model_reset();
        m_state = 1'b0; m_sel = 2'd0; m_phase = 1'b0; m_count = 0; m_prev = 4'b0; m_timeout = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] s, input logic e);
        logic [3:0] press;
        logic [1:0] idx;
        press = s & ~m_prev;
        m_prev = s;
        m_timeout = 1'b0;
        idx = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
        if (press != 4'b0) begin
            if (m_state && idx == m_sel) begin
                m_state = 1'b0; m_sel = 2'd0; m_phase = 1'b0;
            end else begin
                m_state = 1'b1; m_sel = idx; m_phase = 1'b1;
            end
            m_count = 0;
        end else if (m_state && e) begin
`ifdef SELECTIVE_BLINK_TIMEOUT_EN
            if (m_count + 1 == 2 * TB_TIMEOUT - 1) begin
                m_state = 1'b0; m_sel = 2'd0; m_phase = 1'b0; m_count = 0; m_timeout = 1'b1;
            end else begin
                m_phase = ~m_phase;
                m_count++;
            end
`else
            m_phase = ~m_phase;
            if (m_count < 255) m_count++;
`endif
        end
    endtask

    task automatic compare_outputs(input string tag);
        logic [7:0] exp;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 8'h01, 8'h00);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, {a_led4, a_led3, a_led2, a_led1, a_busy, a_sel, a_to}, exp);
            check_eq({tag, "_low"}, {b_led4, b_led3, b_led2, b_led1, b_busy, b_sel, b_to},
                     {~exp[7:4], exp[3:0]});
        end
    endtask

    task automatic step(input logic [3:0] s, input logic e, input string tag);
        @(negedge clk);
        sw = s;
        en = e;
        model_step(s, e);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sw = 4'b0;
        model_reset();
        repeat (2) @(negedge clk);
        exp_q.push_back(model_out());
        compare_outputs("reset_state");
        rst = 1'b0;

        // Select LED_3, then three ticks
        step(4'b0100, 1'b0, "select3");
        step(4'b0000, 1'b1, "tick1");
        step(4'b0000, 1'b1, "tick2");
        step(4'b0000, 1'b1, "tick3");

        // Reselect to LED_1, then stop with a second press of Switch_1
        step(4'b0001, 1'b0, "reselect1");
        step(4'b0000, 1'b0, "release1");
        step(4'b0001, 1'b0, "stop1");
        step(4'b0000, 1'b0, "idle_after_stop");
        step(4'b0000, 1'b1, "idle_tick_ignored");

        // Collision, press with tick, long hold
        step(4'b1010, 1'b0, "collide_2_4");
        step(4'b0000, 1'b1, "tick_after_collide");
        step(4'b0100, 1'b1, "press_with_tick");
        for (int i = 0; i < 100; i++) step(4'b0100, 1'b0, "held_switch");
        step(4'b0000, 1'b0, "held_release");

        // Asynchronous reset mid-blink, observed before the next edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        exp_q.push_back(model_out());
        compare_outputs("async_reset");
        @(negedge clk);
        rst = 1'b0;

        // Auto-stop (or continued blinking when the feature is off) on LED_2
        step(4'b0010, 1'b0, "select2");
        for (int i = 0; i < 4; i++) step(4'b0000, 1'b1, "timeout_ticks");

        // Long run of ticks on LED_4 exercises count saturation
        step(4'b1000, 1'b0, "select4");
        for (int i = 0; i < 300; i++) step(4'b0000, 1'b1, "tick300");
        step(4'b0000, 1'b0, "after_tick300");

        // Random presses and ticks
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 2) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
